// File: rtl/fsm_stream_pkg.sv
// Shared types and sizing helpers for the serial feeder in front of the sequence-detector FSM.
package fsm_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } ser_state_t;

    // Counter width able to hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ser_down_counter.sv
// Loadable down-counter that parks at zero and flags terminal count.
module ser_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and presents one bit per clock on x,
// with an optional idle gap between words.
module bit_serializer
    import fsm_stream_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int BIT_CNT_W = cnt_width(WIDTH);
    localparam int GAP_CNT_W = cnt_width(GAP + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LOAD = BIT_CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             x_q;
    logic             x_d;

    logic accept;
    logic start_word;
    logic bit_load;
    logic bit_dec;
    logic bit_tc;
    logic gap_load;
    logic gap_dec;
    logic gap_tc;

    ser_down_counter #(.W(BIT_CNT_W)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (bit_load),
        .load_value (BIT_LOAD),
        .dec        (bit_dec),
        .tc         (bit_tc)
    );

    ser_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .dec        (gap_dec),
        .tc         (gap_tc)
    );

    // Ready in idle, on the last bit when streaming back-to-back, and in the final gap cycle.
    always_comb begin
        load_ready = 1'b0;
        unique case (state_q)
            S_IDLE:  load_ready = 1'b1;
            S_SHIFT: load_ready = bit_tc && (GAP == 0);
            S_GAP:   load_ready = gap_tc;
            default: load_ready = 1'b0;
        endcase
    end

    assign accept = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        x_d        = IDLE_LEVEL;
        start_word = 1'b0;
        bit_load   = 1'b0;
        bit_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                start_word = accept;
            end
            S_SHIFT: begin
                if (!bit_tc) begin
                    bit_dec = 1'b1;
                    x_d     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                end else if (GAP > 0) begin
                    state_d  = S_GAP;
                    gap_load = 1'b1;
                end else if (accept) begin
                    start_word = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (!gap_tc) begin
                    gap_dec = 1'b1;
                end else if (accept) begin
                    start_word = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The first bit goes straight to x; the rest wait in the shift register.
        if (start_word) begin
            state_d  = S_SHIFT;
            bit_load = 1'b1;
            x_d      = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            shift_d  = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            x_q     <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            x_q     <= x_d;
        end
    end

    assign x       = x_q;
    assign x_valid = (state_q == S_SHIFT);
    assign x_last  = x_valid && bit_tc;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: directed vector tables on three 4-bit configs plus a randomized run
// of a 6-bit LSB-first, GAP=2, idle-high instance against a word/gap queue model.
module tb_bit_serializer;

    typedef struct packed {
        logic       lv;
        logic [3:0] ld;
        logic       ex;
        logic       ev;
        logic       el;
        logic       er;
        logic       eb;
    } vec_t;

    typedef struct packed {
        logic x;
        logic v;
        logic l;
    } beat_t;

    localparam int RW = 6;
    localparam int RGAP = 2;
    localparam logic RIDLE = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       lv_t [3];
    logic [3:0] ld_t [3];
    logic       rdy_o[3];
    logic       x_o  [3];
    logic       v_o  [3];
    logic       l_o  [3];
    logic       b_o  [3];

    logic          lv_r = 1'b0;
    logic [RW-1:0] ld_r = '0;
    logic          rdy_r;
    logic          x_r;
    logic          v_r;
    logic          l_r;
    logic          b_r;

    int tests = 0;
    int failures = 0;

    vec_t  tbl[$];
    beat_t pending[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .load_valid(lv_t[0]), .load_ready(rdy_o[0]),
        .load_data(ld_t[0]), .x(x_o[0]), .x_valid(v_o[0]), .x_last(l_o[0]), .busy(b_o[0])
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .load_valid(lv_t[1]), .load_ready(rdy_o[1]),
        .load_data(ld_t[1]), .x(x_o[1]), .x_valid(v_o[1]), .x_last(l_o[1]), .busy(b_o[1])
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .reset(reset), .load_valid(lv_t[2]), .load_ready(rdy_o[2]),
        .load_data(ld_t[2]), .x(x_o[2]), .x_valid(v_o[2]), .x_last(l_o[2]), .busy(b_o[2])
    );

    bit_serializer #(.WIDTH(RW), .MSB_FIRST(1'b0), .GAP(RGAP), .IDLE_LEVEL(RIDLE)) dut_r (
        .clk(clk), .reset(reset), .load_valid(lv_r), .load_ready(rdy_r),
        .load_data(ld_r), .x(x_r), .x_valid(v_r), .x_last(l_r), .busy(b_r)
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic lv, input logic [3:0] ld);
        lv_t[d] = lv;
        ld_t[d] = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkRow(input int d, input string tag, input vec_t e);
        checkOutput({tag, ".x"}, x_o[d], e.ex);
        checkOutput({tag, ".x_valid"}, v_o[d], e.ev);
        checkOutput({tag, ".x_last"}, l_o[d], e.el);
        checkOutput({tag, ".load_ready"}, rdy_o[d], e.er);
        checkOutput({tag, ".busy"}, b_o[d], e.eb);
    endtask

    task automatic applyTable(input int d, input string tag);
        foreach (tbl[i]) begin
            applyStimulus(d, tbl[i].lv, tbl[i].ld);
            checkRow(d, $sformatf("%s[%0d]", tag, i), tbl[i]);
        end
        lv_t[d] = 1'b0;
    endtask

    task automatic randomRun(input int cycles);
        beat_t e;
        logic  rst;
        logic  lv;
        logic [RW-1:0] ld;
        logic  model_ready;
        logic  busy_exp;
        for (int c = 0; c < cycles; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            lv  = ($urandom_range(0, 2) != 0);
            ld  = RW'($urandom);
            model_ready = (pending.size() == 0);
            reset = rst;
            lv_r  = lv;
            ld_r  = ld;
            @(posedge clk);
            #1;
            if (rst) begin
                pending.delete();
            end else if (lv && model_ready) begin
                for (int i = 0; i < RW; i++) pending.push_back('{ld[i], 1'b1, (i == RW - 1)});
                for (int g = 0; g < RGAP; g++) pending.push_back('{RIDLE, 1'b0, 1'b0});
            end
            if (pending.size() > 0) begin
                e = pending.pop_front();
                busy_exp = 1'b1;
            end else begin
                e = '{RIDLE, 1'b0, 1'b0};
                busy_exp = 1'b0;
            end
            checkOutput($sformatf("R[%0d].x", c), x_r, e.x);
            checkOutput($sformatf("R[%0d].x_valid", c), v_r, e.v);
            checkOutput($sformatf("R[%0d].x_last", c), l_r, e.l);
            checkOutput($sformatf("R[%0d].load_ready", c), rdy_r, pending.size() == 0);
            checkOutput($sformatf("R[%0d].busy", c), b_r, busy_exp);
        end
        reset = 1'b0;
        lv_r  = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            lv_t[d] = 1'b0;
            ld_t[d] = 4'b0000;
        end

        // Two reset edges, with a load offered on A that must be ignored.
        lv_t[0] = 1'b1;
        ld_t[0] = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkRow(d, $sformatf("reset%0d", d), '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        checkOutput("resetR.x", x_r, RIDLE);
        checkOutput("resetR.busy", b_r, 1'b0);
        lv_t[0] = 1'b0;
        reset = 1'b0;

        // A: MSB first, GAP=1; second word offered at the last bit (refused) and taken in the gap.
        tbl = '{};
        tbl.push_back('{1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        applyTable(0, "A");

        // B: LSB first; load_data scrambled while the word is in flight.
        tbl = '{};
        tbl.push_back('{1'b1, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        applyTable(1, "B");

        // C: GAP=0 back-to-back streaming, then 0101 twice as the detector's input stream.
        tbl = '{};
        tbl.push_back('{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        applyTable(2, "C");

        // Reset after the second bit of 1011 on A, with load_valid held through reset.
        applyStimulus(0, 1'b1, 4'b1011);
        checkOutput("rstseq.bit1", x_o[0], 1'b1);
        applyStimulus(0, 1'b0, 4'b1011);
        checkOutput("rstseq.bit2", x_o[0], 1'b0);
        checkOutput("rstseq.bit2_valid", v_o[0], 1'b1);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1'b1, 4'b1111);
            checkRow(0, $sformatf("rstseq.in_reset%0d", k), '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b0, 4'b1111);
            checkRow(0, $sformatf("rstseq.after%0d", k), '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end

        randomRun(400);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
